eth_bus_sched: RTL and testbench
================================

ETH_BUS_SCHED -- requirements
Module: eth_bus_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the max cycles spent waiting for a read response (range 1-255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port rx_payload  input  40  received command: [32] rw (1=write), [31:16] addr, [15:0] data, [39:33] ignored.
REQ-005 SHALL have port rx_valid  input  1  single-cycle strobe qualifying rx_payload.
REQ-006 SHALL have port bus_addr_o  output  16  bus address.
REQ-007 SHALL have port bus_data_o  output  16  bus write data.
REQ-008 SHALL have port bus_rw_o  output  1  bus direction (1=write).
REQ-009 SHALL have port bus_valid_o  output  1  one-cycle bus request strobe.
REQ-010 SHALL have port bus_data_i  input  16  read response data.
REQ-011 SHALL have port bus_valid_i  input  1  read response strobe.
REQ-012 SHALL have port tx_data  output  16  read data for the transmit path.
REQ-013 SHALL have port tx_start  output  1  one-cycle strobe starting a reply transmission.
REQ-014 SHALL have port tx_done  input  1  strobe: reply transmission finished.
REQ-015 SHALL have port drop_count  output  8  commands dropped on FIFO full, saturating.
REQ-016 SHALL have port timeout_count  output  8  read timeouts, saturating.
REQ-017 SHALL have port busy  output  1  high when state != IDLE or FIFO non-empty.

Function
REQ-018 SHALL buffer commands in a 4-entry FIFO; push on rx_valid when not full.
REQ-019 SHALL evaluate full before any same-cycle pop; rx_valid while full is dropped even if a pop occurs that cycle.
REQ-020 SHALL increment drop_count per dropped command, saturating at 255.
REQ-021 SHALL implement states IDLE, ISSUE, WAIT_READ, SEND_TX.
REQ-022 IDLE: FIFO non-empty -> pop head into command register, go ISSUE; else stay.
REQ-023 ISSUE: bus_valid_o=1 for exactly this cycle with addr/data/rw from command register; write -> IDLE; read -> WAIT_READ with timer cleared to 0.
REQ-024 WAIT_READ: bus_valid_i -> capture bus_data_i into tx_data, assert tx_start next cycle, go SEND_TX.
REQ-025 WAIT_READ: timer increments each cycle without bus_valid_i; at timer == TIMEOUT-1 without response -> IDLE, timeout_count +1 (saturating at 255), tx_start not asserted.
REQ-026 SEND_TX: tx_start high only on the first cycle in state; stay until tx_done, then IDLE.
REQ-027 SHALL ignore bus_valid_i outside WAIT_READ and tx_done outside SEND_TX.
REQ-028 Latency: rx_valid at cycle N into empty FIFO with state IDLE -> bus_valid_o high at N+2.
REQ-029 Throughput: back-to-back writes issue one bus_valid_o every 2 cycles.
REQ-030 bus_addr_o/bus_data_o/bus_rw_o SHALL hold their last values while bus_valid_o is low.
REQ-031 tx_data SHALL hold the last captured read value until the next capture.
REQ-032 FIFO order SHALL be preserved; no command issued twice or skipped except drops per REQ-019.

Reset
REQ-033 rst SHALL set state IDLE, empty the FIFO, clear timer, drop_count, timeout_count, and drive all outputs to 0.
REQ-034 rst mid-operation (any state) SHALL discard FIFO contents and any pending read/reply; no bus_valid_o or tx_start in the cycle after rst is released.
REQ-035 rx_valid coincident with rst SHALL be discarded.

Verification
REQ-036 Write: rx_payload=0x1_1234_ABCD, rx_valid at N -> bus_valid_o at N+2, bus_addr_o=0x1234, bus_data_o=0xABCD, bus_rw_o=1; no tx_start.
REQ-037 Read: rx_payload=0x0_0010_0000; bus_valid_i with bus_data_i=0x5A5A 3 cycles after request -> tx_data=0x5A5A, one tx_start pulse; tx_done -> busy falls next cycle.
REQ-038 Overflow: read held in WAIT_READ, 6 rx_valid strobes -> 4 queued, drop_count=2, then issued in arrival order.
REQ-039 Timeout: TIMEOUT=8, read never answered -> return to IDLE after 8 WAIT_READ cycles, timeout_count=1, no tx_start; late bus_valid_i ignored.
REQ-040 Reset: rst asserted in SEND_TX with 2 commands queued -> all outputs 0, busy=0, no bus activity after release.

Source files
------------

// File: rtl/eth_bus_sched.sv
// eth_bus_sched
//
// Takes commands arriving from the receive path, queues them in a 4-entry
// FIFO and replays them one at a time onto a simple request/response bus.
// Writes are fire-and-forget. Reads wait for a response (bounded by
// TIMEOUT cycles) and hand the returned data to the transmit path.
//
// Parameters
//   TIMEOUT        max cycles spent in WAIT_READ before giving up (1-255)
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   rx_payload     command: [32] rw (1=write), [31:16] addr, [15:0] data
//   rx_valid       single-cycle strobe qualifying rx_payload
//   bus_addr_o     bus address (holds between requests)
//   bus_data_o     bus write data (holds between requests)
//   bus_rw_o       bus direction, 1=write (holds between requests)
//   bus_valid_o    one-cycle bus request strobe
//   bus_data_i     read response data
//   bus_valid_i    read response strobe
//   tx_data        last read value captured for the transmit path
//   tx_start       one-cycle strobe starting a reply transmission
//   tx_done        reply transmission finished
//   drop_count     commands dropped because the FIFO was full (saturating)
//   timeout_count  read timeouts (saturating)
//   busy           state is not IDLE or the FIFO holds commands

module eth_bus_sched #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] rx_payload,
    input  logic        rx_valid,
    output logic [15:0] bus_addr_o,
    output logic [15:0] bus_data_o,
    output logic        bus_rw_o,
    output logic        bus_valid_o,
    input  logic [15:0] bus_data_i,
    input  logic        bus_valid_i,
    output logic [15:0] tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic [7:0]  drop_count,
    output logic [7:0]  timeout_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_READ,
        SEND_TX
    } state_t;

    // The timer counts 0..TIMEOUT-1, so the read gives up after exactly
    // TIMEOUT cycles spent in WAIT_READ.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [32:0] fifo_q [4];
    logic [32:0] fifo_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [15:0] bus_data_q, bus_data_d;
    logic        bus_rw_q, bus_rw_d;
    logic        bus_valid_q, bus_valid_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  timer_q, timer_d;
    logic [7:0]  drop_count_q, drop_count_d;
    logic [7:0]  timeout_count_q, timeout_count_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    // Upper payload bits carry nothing for this block.
    logic unused_payload_bits;
    assign unused_payload_bits = ^rx_payload[39:33];

    assign fifo_full  = (count_q == 3'd4);
    assign fifo_empty = (count_q == 3'd0);

    // Next-state logic for the scheduler FSM, the FIFO and the counters.
    // The bus output registers double as the command register: they are
    // loaded straight from the FIFO head on the IDLE->ISSUE transition, so
    // they only ever change in the same cycle bus_valid_o rises and hold
    // steady the rest of the time. Fullness is judged on the registered
    // count, so a strobe arriving while full is dropped even when the FSM
    // pops in that same cycle.
    always_comb begin
        state_d         = state_q;
        fifo_d          = fifo_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        bus_addr_d      = bus_addr_q;
        bus_data_d      = bus_data_q;
        bus_rw_d        = bus_rw_q;
        bus_valid_d     = 1'b0;
        tx_data_d       = tx_data_q;
        tx_start_d      = 1'b0;
        timer_d         = timer_q;
        drop_count_d    = drop_count_q;
        timeout_count_d = timeout_count_q;
        push            = rx_valid && !fifo_full;
        pop             = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    {bus_rw_d, bus_addr_d, bus_data_d} = fifo_q[rd_ptr_q];
                    bus_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus_rw_q) begin
                    state_d = IDLE;
                end else begin
                    timer_d = 8'd0;
                    state_d = WAIT_READ;
                end
            end
            WAIT_READ: begin
                if (bus_valid_i) begin
                    tx_data_d  = bus_data_i;
                    tx_start_d = 1'b1;
                    state_d    = SEND_TX;
                end else if (timer_q == TIMER_LAST) begin
                    if (timeout_count_q != 8'hFF) begin
                        timeout_count_d = timeout_count_q + 8'd1;
                    end
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            SEND_TX: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push) begin
            fifo_d[wr_ptr_q] = rx_payload[32:0];
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end else if (rx_valid && drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        count_d = count_q + {2'b00, push} - {2'b00, pop};
    end

    // State register. Reset clears everything, so any queued commands and
    // any read or reply in flight are simply forgotten.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            fifo_q          <= '{default: '0};
            wr_ptr_q        <= 2'd0;
            rd_ptr_q        <= 2'd0;
            count_q         <= 3'd0;
            bus_addr_q      <= 16'd0;
            bus_data_q      <= 16'd0;
            bus_rw_q        <= 1'b0;
            bus_valid_q     <= 1'b0;
            tx_data_q       <= 16'd0;
            tx_start_q      <= 1'b0;
            timer_q         <= 8'd0;
            drop_count_q    <= 8'd0;
            timeout_count_q <= 8'd0;
        end else begin
            state_q         <= state_d;
            fifo_q          <= fifo_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            bus_addr_q      <= bus_addr_d;
            bus_data_q      <= bus_data_d;
            bus_rw_q        <= bus_rw_d;
            bus_valid_q     <= bus_valid_d;
            tx_data_q       <= tx_data_d;
            tx_start_q      <= tx_start_d;
            timer_q         <= timer_d;
            drop_count_q    <= drop_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign bus_addr_o    = bus_addr_q;
    assign bus_data_o    = bus_data_q;
    assign bus_rw_o      = bus_rw_q;
    assign bus_valid_o   = bus_valid_q;
    assign tx_data       = tx_data_q;
    assign tx_start      = tx_start_q;
    assign drop_count    = drop_count_q;
    assign timeout_count = timeout_count_q;
    assign busy          = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_eth_bus_sched.sv
// tb_eth_bus_sched
//
// Directed bench for eth_bus_sched (TIMEOUT=8). Every accepted command is
// pushed to a bus scoreboard when it is driven, and every expected reply is
// pushed to a tx scoreboard when the read response is driven; a monitor
// pops and compares whenever the DUT strobes bus_valid_o or tx_start.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_eth_bus_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] rx_payload;
    logic        rx_valid;
    logic [15:0] bus_addr_o;
    logic [15:0] bus_data_o;
    logic        bus_rw_o;
    logic        bus_valid_o;
    logic [15:0] bus_data_i;
    logic        bus_valid_i;
    logic [15:0] tx_data;
    logic        tx_start;
    logic        tx_done;
    logic [7:0]  drop_count;
    logic [7:0]  timeout_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [32:0] busQ [$];
    logic [15:0] txQ [$];

    eth_bus_sched #(.TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_payload    (rx_payload),
        .rx_valid      (rx_valid),
        .bus_addr_o    (bus_addr_o),
        .bus_data_o    (bus_data_o),
        .bus_rw_o      (bus_rw_o),
        .bus_valid_o   (bus_valid_o),
        .bus_data_i    (bus_data_i),
        .bus_valid_i   (bus_valid_i),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_done       (tx_done),
        .drop_count    (drop_count),
        .timeout_count (timeout_count),
        .busy          (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one rx strobe for a single cycle; accepted commands go to the
    // bus scoreboard in arrival order.
    task automatic applyStimulus(input logic [39:0] payload, input bit accepted);
        rx_payload = payload;
        rx_valid   = 1'b1;
        if (accepted) begin
            busQ.push_back(payload[32:0]);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_bus_valid"}, {39'd0, bus_valid_o}, 40'd0);
        checkOutput({tag, "_bus_addr"}, {24'd0, bus_addr_o}, 40'd0);
        checkOutput({tag, "_bus_data"}, {24'd0, bus_data_o}, 40'd0);
        checkOutput({tag, "_bus_rw"}, {39'd0, bus_rw_o}, 40'd0);
        checkOutput({tag, "_tx_data"}, {24'd0, tx_data}, 40'd0);
        checkOutput({tag, "_tx_start"}, {39'd0, tx_start}, 40'd0);
        checkOutput({tag, "_drop"}, {32'd0, drop_count}, 40'd0);
        checkOutput({tag, "_timeout"}, {32'd0, timeout_count}, 40'd0);
        checkOutput({tag, "_busy"}, {39'd0, busy}, 40'd0);
    endtask

    // Scoreboard monitor: each bus request and each reply start must match
    // the oldest outstanding expectation; a strobe with nothing expected
    // is reported as unexpected.
    always @(negedge clk) begin
        logic [32:0] expBus;
        logic [15:0] expTx;
        if (bus_valid_o === 1'b1) begin
            if (busQ.size() == 0) begin
                checkOutput("bus_unexpected", {39'd0, bus_valid_o}, 40'd0);
            end else begin
                expBus = busQ.pop_front();
                checkOutput("bus_txn", {7'd0, bus_rw_o, bus_addr_o, bus_data_o}, {7'd0, expBus});
            end
        end
        if (tx_start === 1'b1) begin
            if (txQ.size() == 0) begin
                checkOutput("tx_unexpected", {39'd0, tx_start}, 40'd0);
            end else begin
                expTx = txQ.pop_front();
                checkOutput("tx_data", {24'd0, tx_data}, {24'd0, expTx});
            end
        end
    end

    initial begin
        // Reset with a coincident rx strobe that must be discarded.
        rst         = 1'b1;
        rx_valid    = 1'b1;
        rx_payload  = 40'h01_FFFF_FFFF;
        bus_data_i  = 16'd0;
        bus_valid_i = 1'b0;
        tx_done     = 1'b0;
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        rx_valid   = 1'b0;
        rx_payload = 40'd0;
        checkResetState("reset");
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_discard_busy", {39'd0, busy}, 40'd0);

        // Write: bus request two cycles after the strobe, then hold.
        applyStimulus(40'h01_1234_ABCD, 1'b1);
        checkOutput("wr_lat_n1", {39'd0, bus_valid_o}, 40'd0);
        @(negedge clk);
        checkOutput("wr_lat_n2", {39'd0, bus_valid_o}, 40'd1);
        repeat (3) @(negedge clk);
        checkOutput("wr_hold", {7'd0, bus_rw_o, bus_addr_o, bus_data_o}, {7'd0, 1'b1, 16'h1234, 16'hABCD});
        checkOutput("wr_idle_busy", {39'd0, busy}, 40'd0);

        // Read answered three cycles after the request.
        applyStimulus(40'h00_0010_0000, 1'b1);
        @(negedge clk);
        checkOutput("rd_req", {39'd0, bus_valid_o}, 40'd1);
        repeat (3) @(negedge clk);
        bus_valid_i = 1'b1;
        bus_data_i  = 16'h5A5A;
        txQ.push_back(16'h5A5A);
        @(negedge clk);
        bus_valid_i = 1'b0;
        checkOutput("rd_tx_start", {39'd0, tx_start}, 40'd1);
        @(negedge clk);
        checkOutput("rd_tx_start_single", {39'd0, tx_start}, 40'd0);
        tx_done = 1'b1;
        checkOutput("rd_busy_before_done", {39'd0, busy}, 40'd1);
        @(negedge clk);
        tx_done = 1'b0;
        checkOutput("rd_busy_after_done", {39'd0, busy}, 40'd0);

        // Read that is never answered: 8 WAIT_READ cycles, then IDLE.
        applyStimulus(40'h00_0020_0000, 1'b1);
        @(negedge clk);
        repeat (8) @(negedge clk);
        checkOutput("to_busy_last_wait", {39'd0, busy}, 40'd1);
        checkOutput("to_count_before", {32'd0, timeout_count}, 40'd0);
        @(negedge clk);
        checkOutput("to_busy_after", {39'd0, busy}, 40'd0);
        checkOutput("to_count_after", {32'd0, timeout_count}, 40'd1);
        bus_valid_i = 1'b1;
        bus_data_i  = 16'hDEAD;
        @(negedge clk);
        bus_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("to_late_resp_tx_data", {24'd0, tx_data}, {24'd0, 16'h5A5A});
        checkOutput("to_late_resp_busy", {39'd0, busy}, 40'd0);

        // Overflow: six strobes while a read waits, four kept, two dropped.
        applyStimulus(40'h00_0030_0000, 1'b1);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(40'h01_0A01_0001, 1'b1);
        applyStimulus(40'h01_0A02_0002, 1'b1);
        applyStimulus(40'h01_0A03_0003, 1'b1);
        applyStimulus(40'h01_0A04_0004, 1'b1);
        applyStimulus(40'h01_0A05_0005, 1'b0);
        applyStimulus(40'h01_0A06_0006, 1'b0);
        checkOutput("ovf_drop2", {32'd0, drop_count}, 40'd2);
        bus_valid_i = 1'b1;
        bus_data_i  = 16'h1111;
        txQ.push_back(16'h1111);
        @(negedge clk);
        bus_valid_i = 1'b0;
        tx_done     = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        // Strobe while full in the same cycle as the first pop: dropped.
        applyStimulus(40'h01_0A07_0007, 1'b0);
        checkOutput("thr_slot0", {39'd0, bus_valid_o}, 40'd1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("thr_slot%0d", i), {39'd0, bus_valid_o}, {39'd0, (i % 2 == 0)});
        end
        checkOutput("ovf_drop3", {32'd0, drop_count}, 40'd3);
        checkOutput("ovf_busy_end", {39'd0, busy}, 40'd0);

        // Reset in SEND_TX with two commands queued.
        applyStimulus(40'h00_0040_0000, 1'b1);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(40'h01_0B01_0001, 1'b0);
        applyStimulus(40'h01_0B02_0002, 1'b0);
        bus_valid_i = 1'b1;
        bus_data_i  = 16'h2222;
        txQ.push_back(16'h2222);
        @(negedge clk);
        bus_valid_i = 1'b0;
        checkOutput("rst_in_send_tx", {39'd0, tx_start}, 40'd1);
        rst = 1'b1;
        @(negedge clk);
        checkResetState("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkResetState("rst_release");
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("rst_quiet_busy", {39'd0, busy}, 40'd0);

        checkOutput("bus_queue_drained", 40'(busQ.size()), 40'd0);
        checkOutput("tx_queue_drained", 40'(txQ.size()), 40'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
